// File: rtl/cgra_pkg.sv
// cgra_pkg: shared CGRA sizing constants and the context-memory loader FSM state type.
package cgra_pkg;

  localparam int N_ROW             = 4;
  localparam int IMEM_N_LINES      = 32;
  localparam int IMEM_N_LINES_LOG2 = $clog2(IMEM_N_LINES);
  localparam int DATA_WIDTH        = 32;
  localparam int ADDR_W            = IMEM_N_LINES_LOG2;
  localparam int ROW_W             = (N_ROW > 1) ? $clog2(N_ROW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } cmem_loader_state_t;

endpackage

// File: rtl/cmem_loader_if.sv
// cmem_loader_if: kernel command, word stream and context-memory write port of cmem_loader.
// checksum_i exists only when CMEM_LOADER_CHECKSUM_EN is defined.
interface cmem_loader_if
  import cgra_pkg::*;
();

  logic                  start_i;
  logic [ADDR_W-1:0]     base_addr_i;
  logic [ADDR_W:0]       n_lines_i;
  logic [N_ROW-1:0]      row_mask_i;
  logic                  abort_i;
`ifdef CMEM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_i;
`endif
  logic                  data_valid_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  data_ready_o;
  logic [N_ROW-1:0]      cm_row_req_o;
  logic                  cm_we_o;
  logic [ADDR_W-1:0]     cm_addr_o;
  logic [DATA_WIDTH-1:0] cm_wdata_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  error_o;

  modport slave (
`ifdef CMEM_LOADER_CHECKSUM_EN
    input  checksum_i,
`endif
    input  start_i, base_addr_i, n_lines_i, row_mask_i, abort_i,
    input  data_valid_i, data_i,
    output data_ready_o, cm_row_req_o, cm_we_o, cm_addr_o, cm_wdata_o,
    output busy_o, done_o, error_o
  );

  modport master (
`ifdef CMEM_LOADER_CHECKSUM_EN
    output checksum_i,
`endif
    output start_i, base_addr_i, n_lines_i, row_mask_i, abort_i,
    output data_valid_i, data_i,
    input  data_ready_o, cm_row_req_o, cm_we_o, cm_addr_o, cm_wdata_o,
    input  busy_o, done_o, error_o
  );

endinterface

// File: rtl/cmem_loader_row_sel.sv
// cmem_loader_row_sel: finds the lowest set mask bit at an index >= from_row_i.
module cmem_loader_row_sel
  import cgra_pkg::*;
(
  input  logic [N_ROW-1:0] mask_i,
  input  logic [ROW_W:0]   from_row_i,
  output logic [ROW_W-1:0] next_row_o,
  output logic             valid_o
);

  // Scanning downward lets the lowest qualifying bit win.
  always_comb begin
    next_row_o = '0;
    valid_o    = 1'b0;
    for (int i = N_ROW - 1; i >= 0; i--) begin
      if (mask_i[i] && ((ROW_W+1)'(i) >= from_row_i)) begin
        next_row_o = ROW_W'(i);
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmem_loader.sv
// cmem_loader: writes a streamed line range into each selected CGRA context memory row.
// Optional running-sum check against checksum_i is enabled by CMEM_LOADER_CHECKSUM_EN.
module cmem_loader
  import cgra_pkg::*;
(
  input logic          clk_i,
  input logic          rst_i,
  cmem_loader_if.slave bus
);

  cmem_loader_state_t    state_q, state_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [ADDR_W:0]       nLines_q, nLines_d;
  logic [N_ROW-1:0]      mask_q, mask_d;
  logic                  errFlag_q, errFlag_d;
  logic [ROW_W-1:0]      curRow_q, curRow_d;
  logic [ADDR_W-1:0]     line_q, line_d;
  logic                  cmWe_q, cmWe_d;
  logic [N_ROW-1:0]      cmRow_q, cmRow_d;
  logic [ADDR_W-1:0]     cmAddr_q, cmAddr_d;
  logic [DATA_WIDTH-1:0] cmWdata_q, cmWdata_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef CMEM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
`endif

  logic [ROW_W-1:0] firstRow, nextRow;
  logic             firstValid, nextValid;
  logic             handshake, lastLine, rangeErr, finError;

  cmem_loader_row_sel u_first_sel (
    .mask_i     (bus.row_mask_i),
    .from_row_i ('0),
    .next_row_o (firstRow),
    .valid_o    (firstValid)
  );

  cmem_loader_row_sel u_next_sel (
    .mask_i     (mask_q),
    .from_row_i ({1'b0, curRow_q} + (ROW_W+1)'(1)),
    .next_row_o (nextRow),
    .valid_o    (nextValid)
  );

  // Range is checked two bits wider than the address so base+n never overflows.
  assign rangeErr  = ({2'b00, bus.base_addr_i} + {1'b0, bus.n_lines_i}) > (ADDR_W+2)'(IMEM_N_LINES);
  assign handshake = (state_q == LOAD) && bus.data_valid_i;
  assign lastLine  = ({1'b0, line_q} == (nLines_q - (ADDR_W+1)'(1)));
`ifdef CMEM_LOADER_CHECKSUM_EN
  assign finError  = errFlag_q || (sum_q != checksum_q);
`else
  assign finError  = errFlag_q;
`endif

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    nLines_d  = nLines_q;
    mask_d    = mask_q;
    errFlag_d = errFlag_q;
    curRow_d  = curRow_q;
    line_d    = line_q;
    cmWe_d    = 1'b0;
    cmRow_d   = '0;
    cmAddr_d  = '0;
    cmWdata_d = '0;
    done_d    = 1'b0;
    error_d   = 1'b0;
`ifdef CMEM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
    checksum_d = checksum_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          base_d    = bus.base_addr_i;
          nLines_d  = bus.n_lines_i;
          mask_d    = bus.row_mask_i;
          line_d    = '0;
          curRow_d  = firstRow;
          errFlag_d = rangeErr;
`ifdef CMEM_LOADER_CHECKSUM_EN
          sum_d      = '0;
          checksum_d = bus.checksum_i;
`endif
          if (rangeErr || (bus.n_lines_i == '0) || !firstValid) begin
            state_d = FIN;
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        if (handshake) begin
          cmWe_d    = 1'b1;
          cmRow_d   = N_ROW'(1) << curRow_q;
          cmAddr_d  = base_q + line_q;
          cmWdata_d = bus.data_i;
`ifdef CMEM_LOADER_CHECKSUM_EN
          sum_d     = sum_q + bus.data_i;
`endif
          if (lastLine) begin
            line_d = '0;
            if (nextValid) begin
              curRow_d = nextRow;
            end else begin
              state_d = FIN;
            end
          end else begin
            line_d = line_q + ADDR_W'(1);
          end
        end
        // Abort wins over a final handshake, but that handshake's write still goes out.
        if (bus.abort_i) begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end

      FIN: begin
        state_d = IDLE;
        error_d = finError;
        done_d  = !finError;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      base_q    <= '0;
      nLines_q  <= '0;
      mask_q    <= '0;
      errFlag_q <= 1'b0;
      curRow_q  <= '0;
      line_q    <= '0;
      cmWe_q    <= 1'b0;
      cmRow_q   <= '0;
      cmAddr_q  <= '0;
      cmWdata_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
`ifdef CMEM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
      checksum_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      nLines_q  <= nLines_d;
      mask_q    <= mask_d;
      errFlag_q <= errFlag_d;
      curRow_q  <= curRow_d;
      line_q    <= line_d;
      cmWe_q    <= cmWe_d;
      cmRow_q   <= cmRow_d;
      cmAddr_q  <= cmAddr_d;
      cmWdata_q <= cmWdata_d;
      done_q    <= done_d;
      error_q   <= error_d;
`ifdef CMEM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
      checksum_q <= checksum_d;
`endif
    end
  end

  assign bus.data_ready_o = (state_q == LOAD);
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.cm_we_o      = cmWe_q;
  assign bus.cm_row_req_o = cmRow_q;
  assign bus.cm_addr_o    = cmAddr_q;
  assign bus.cm_wdata_o   = cmWdata_q;
  assign bus.done_o       = done_q;
  assign bus.error_o      = error_q;

endmodule

// File: tb/tb_cmem_loader.sv
// tb_cmem_loader: table-driven, hand-written and randomized checks of cmem_loader against
// a line-list reference model; define CMEM_LOADER_CHECKSUM_EN to exercise the checksum path.
module tb_cmem_loader;
  import cgra_pkg::*;

  typedef struct packed {
    logic [N_ROW-1:0]      row;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_WIDTH-1:0] data;
    logic [31:0]           cyc;
  } wr_t;

  typedef struct {
    string            name;
    int               base;
    int               n;
    logic [N_ROW-1:0] mask;
    int               validPct;
    int               pat;
    int               patLen;
    int               abortAfter;
    bit               abortValid;
    int               wordBase;
    int               chkDelta;
    int               expWrites;
    int               expDone;
    int               expError;
  } vec_t;

  localparam int BUDGET = 2000;

  logic clk = 1'b0;
  logic rst;
  cmem_loader_if bus();

  cmem_loader dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   failures = 0;
  wr_t  obsQ[$];
  int   doneCnt = 0, errCnt = 0, pulseCyc = 0, zeroViol = 0, bothViol = 0;
  logic pulseBusy = 1'b0;

  // Passive observer of the write port and the completion pulses.
  always @(negedge clk) begin
    if (bus.cm_we_o === 1'b1) begin
      obsQ.push_back('{row: bus.cm_row_req_o, addr: bus.cm_addr_o, data: bus.cm_wdata_o, cyc: 32'(cyc)});
    end else if ((bus.cm_row_req_o !== '0) || (bus.cm_addr_o !== '0) || (bus.cm_wdata_o !== '0)) begin
      zeroViol++;
    end
    if (bus.done_o === 1'b1) begin doneCnt++; pulseCyc = cyc; pulseBusy = bus.busy_o; end
    if (bus.error_o === 1'b1) begin errCnt++; pulseCyc = cyc; pulseBusy = bus.busy_o; end
    if ((bus.done_o === 1'b1) && (bus.error_o === 1'b1)) bothViol++;
  end

  function automatic logic [63:0] outVec();
    return 64'({bus.cm_we_o, bus.cm_row_req_o, bus.cm_addr_o, bus.cm_wdata_o,
                bus.data_ready_o, bus.busy_o, bus.done_o, bus.error_o});
  endfunction

  task automatic checkOutput(input string what, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", what, act, req);
    end
  endtask

  task automatic clearObs();
    obsQ.delete();
    doneCnt = 0; errCnt = 0; pulseCyc = -100; zeroViol = 0; bothViol = 0; pulseBusy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command, streams its words and compares against the line-list model.
  task automatic applyStimulus(input string name, input int base, input int n, input logic [N_ROW-1:0] mask,
                               input int validPct, input int pat, input int patLen,
                               input int abortAfter, input bit abortValid,
                               input int wordBase, input int chkDelta,
                               output int nWrites, output int nDone, output int nErr);
    logic [DATA_WIDTH-1:0] words[$];
    logic [DATA_WIDTH-1:0] sum;
    logic [31:0]           patBits;
    wr_t                   expQ[$];
    bit                    rangeErr, loads, abortEn, mismatch, expErr, v;
    int                    total, hs, budget, startCyc, abortCyc, nExp;

    rangeErr = (base + n) > IMEM_N_LINES;
    loads    = !rangeErr && (n != 0) && (mask != '0);
    total    = loads ? n * $countones(mask) : 0;
    abortEn  = loads && (abortAfter >= 0) && (abortAfter < total);
    patBits  = 32'(pat);
    sum      = '0;
    for (int k = 0; k < total; k++) begin
      words.push_back((wordBase != 0) ? DATA_WIDTH'(wordBase + k) : DATA_WIDTH'($urandom));
      sum = sum + words[k];
    end
    if (loads) begin
      int k = 0;
      for (int r = 0; r < N_ROW; r++) begin
        if (mask[r]) begin
          for (int l = 0; l < n; l++) begin
            expQ.push_back('{row: N_ROW'(1) << r, addr: ADDR_W'(base + l), data: words[k], cyc: 32'(0)});
            k++;
          end
        end
      end
    end

    clearObs();
    startCyc            = cyc;
    bus.start_i         = 1'b1;
    bus.base_addr_i     = ADDR_W'(base);
    bus.n_lines_i       = (ADDR_W+1)'(n);
    bus.row_mask_i      = mask;
`ifdef CMEM_LOADER_CHECKSUM_EN
    bus.checksum_i      = sum + DATA_WIDTH'(chkDelta);
`endif
    tick();
    bus.start_i     = 1'b0;
    bus.base_addr_i = ADDR_W'($urandom);
    bus.n_lines_i   = (ADDR_W+1)'($urandom);
    bus.row_mask_i  = N_ROW'($urandom);
    checkOutput({name, "_busy_after_start"}, 64'({bus.data_ready_o, bus.busy_o}), 64'({loads, 1'b1}));

    hs = 0; budget = 0; abortCyc = 0;
    nExp = total;
    if (loads) begin
      while ((hs < total) && (budget < BUDGET)) begin
        checkOutput({name, "_ready_busy_in_load"}, 64'({bus.data_ready_o, bus.busy_o}), 64'(2'b11));
        if (abortEn && (hs == abortAfter)) begin
          abortCyc         = cyc;
          bus.abort_i      = 1'b1;
          bus.data_valid_i = abortValid;
          bus.data_i       = words[hs];
          bus.start_i      = 1'b0;
          if (abortValid) expQ[hs].cyc = 32'(cyc + 1);
          nExp = hs + (abortValid ? 1 : 0);
          tick();
          bus.abort_i      = 1'b0;
          bus.data_valid_i = 1'b0;
          checkOutput({name, "_ready_after_abort"}, 64'({bus.data_ready_o, bus.busy_o}), 64'(0));
          break;
        end
        v = (patLen > 0) ? patBits[budget % patLen] : ($urandom_range(99) < validPct);
        bus.data_valid_i = v;
        bus.data_i       = v ? words[hs] : DATA_WIDTH'($urandom);
        bus.start_i      = ($urandom_range(7) == 0);
        if (v) begin
          expQ[hs].cyc = 32'(cyc + 1);
          hs++;
        end
        budget++;
        tick();
      end
      bus.data_valid_i = 1'b0;
      bus.start_i      = 1'b0;
      checkOutput({name, "_cycle_budget"}, 64'(budget < BUDGET), 64'(1));
    end
    repeat (3) tick();

    mismatch = 1'b0;
`ifdef CMEM_LOADER_CHECKSUM_EN
    mismatch = (chkDelta != 0);
`endif
    expErr = abortEn || rangeErr || mismatch;

    checkOutput({name, "_write_count"}, 64'(obsQ.size()), 64'(nExp));
    for (int i = 0; (i < nExp) && (i < obsQ.size()); i++) begin
      checkOutput($sformatf("%s_write%0d_row_addr_data", name, i),
                  64'({obsQ[i].row, obsQ[i].addr, obsQ[i].data}),
                  64'({expQ[i].row, expQ[i].addr, expQ[i].data}));
      checkOutput($sformatf("%s_write%0d_cycle", name, i), 64'(obsQ[i].cyc), 64'(expQ[i].cyc));
    end
    checkOutput({name, "_done_count"}, 64'(doneCnt), 64'(expErr ? 0 : 1));
    checkOutput({name, "_error_count"}, 64'(errCnt), 64'(expErr ? 1 : 0));
    if (abortEn) begin
      checkOutput({name, "_error_cycle"}, 64'(pulseCyc), 64'(abortCyc + 1));
    end else if (loads) begin
      checkOutput({name, "_pulse_cycle"}, 64'(pulseCyc), 64'(expQ[total-1].cyc + 1));
      checkOutput({name, "_busy_at_pulse"}, 64'(pulseBusy), 64'(0));
    end else begin
      checkOutput({name, "_pulse_cycle"}, 64'(pulseCyc), 64'(startCyc + 2));
    end
    checkOutput({name, "_idle_write_port_zero"}, 64'(zeroViol), 64'(0));
    checkOutput({name, "_done_error_exclusive"}, 64'(bothViol), 64'(0));
    checkOutput({name, "_idle_at_end"}, 64'({bus.data_ready_o, bus.busy_o}), 64'(0));

    nWrites = obsQ.size();
    nDone   = doneCnt;
    nErr    = errCnt;
  endtask

  vec_t vecs[12];

  initial begin
    int nW, nD, nE;

    bus.start_i      = 1'b0;
    bus.base_addr_i  = '0;
    bus.n_lines_i    = '0;
    bus.row_mask_i   = '0;
    bus.abort_i      = 1'b0;
    bus.data_valid_i = 1'b0;
    bus.data_i       = '0;
`ifdef CMEM_LOADER_CHECKSUM_EN
    bus.checksum_i   = '0;
`endif
    rst = 1'b1;
    repeat (3) tick();
    checkOutput("reset_outputs", outVec(), 64'(0));
    rst = 1'b0;
    tick();
    checkOutput("post_reset_outputs", outVec(), 64'(0));

    //          name            base n   mask     pct pat       len abrt av    wbase  dChk wr  dn er
    vecs[0]  = '{"single_row",   4,  3, 4'b0010, 100, 0,        0,  -1, 1'b0, 'hA0,  0,   3, 1, 0};
    vecs[1]  = '{"multi_gap",    0,  2, 4'b1010, 0,   'b101101, 6,  -1, 1'b0, 0,     0,   4, 1, 0};
    vecs[2]  = '{"range_err",    30, 3, 4'b1111, 100, 0,        0,  -1, 1'b0, 0,     0,   0, 0, 1};
    vecs[3]  = '{"empty_n",      5,  0, 4'b1111, 100, 0,        0,  -1, 1'b0, 0,     0,   0, 1, 0};
    vecs[4]  = '{"abort5",       0,  4, 4'b1111, 100, 0,        0,  5,  1'b0, 0,     0,   5, 0, 1};
    vecs[5]  = '{"empty_mask",   0,  4, 4'b0000, 100, 0,        0,  -1, 1'b0, 0,     0,   0, 1, 0};
    vecs[6]  = '{"top_boundary", 28, 4, 4'b1001, 70,  0,        0,  -1, 1'b0, 0,     0,   8, 1, 0};
    vecs[7]  = '{"full_mem",     0,  32,4'b0001, 100, 0,        0,  -1, 1'b0, 0,     0,   32,1, 0};
    vecs[8]  = '{"range_by_one", 31, 2, 4'b0001, 100, 0,        0,  -1, 1'b0, 0,     0,   0, 0, 1};
    vecs[9]  = '{"abort_last",   2,  2, 4'b0100, 100, 0,        0,  1,  1'b1, 0,     0,   2, 0, 1};
    vecs[10] = '{"abort_first",  7,  3, 4'b0011, 100, 0,        0,  0,  1'b0, 0,     0,   0, 0, 1};
    vecs[11] = '{"one_line_top", 31, 1, 4'b1000, 50,  0,        0,  -1, 1'b0, 0,     0,   1, 1, 0};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].name, vecs[i].base, vecs[i].n, vecs[i].mask, vecs[i].validPct,
                    vecs[i].pat, vecs[i].patLen, vecs[i].abortAfter, vecs[i].abortValid,
                    vecs[i].wordBase, vecs[i].chkDelta, nW, nD, nE);
      checkOutput({vecs[i].name, "_table_writes"}, 64'(nW), 64'(vecs[i].expWrites));
      checkOutput({vecs[i].name, "_table_done"}, 64'(nD), 64'(vecs[i].expDone));
      checkOutput({vecs[i].name, "_table_error"}, 64'(nE), 64'(vecs[i].expError));
    end

    // Reset while loading: the write from the reset cycle's handshake must be dropped.
    clearObs();
    bus.start_i     = 1'b1;
    bus.base_addr_i = ADDR_W'(3);
    bus.n_lines_i   = (ADDR_W+1)'(5);
    bus.row_mask_i  = 4'b0110;
    tick();
    bus.start_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.data_valid_i = 1'b1;
      bus.data_i       = DATA_WIDTH'(32'h11 + k);
      if (k == 3) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    bus.data_valid_i = 1'b0;
    checkOutput("rst_mid_outputs_zero", outVec(), 64'(0));
    repeat (3) tick();
    checkOutput("rst_mid_write_count", 64'(obsQ.size()), 64'(3));
    if (obsQ.size() == 3) begin
      checkOutput("rst_mid_last_write", 64'({obsQ[2].row, obsQ[2].addr, obsQ[2].data}),
                  64'({4'b0010, 5'd5, 32'h13}));
    end
    checkOutput("rst_mid_no_pulses", 64'({doneCnt[7:0], errCnt[7:0]}), 64'(0));
    applyStimulus("after_rst", 1, 3, 4'b0101, 80, 0, 0, -1, 1'b0, 0, 0, nW, nD, nE);
    checkOutput("after_rst_done", 64'({nW[7:0], nD[7:0], nE[7:0]}), 64'({8'd6, 8'd1, 8'd0}));

`ifdef CMEM_LOADER_CHECKSUM_EN
    applyStimulus("chk_ok", 0, 3, 4'b0001, 100, 0, 0, -1, 1'b0, 1, 0, nW, nD, nE);
    checkOutput("chk_ok_flags", 64'({nD[7:0], nE[7:0]}), 64'({8'd1, 8'd0}));
    applyStimulus("chk_bad", 0, 3, 4'b0001, 100, 0, 0, -1, 1'b0, 1, 1, nW, nD, nE);
    checkOutput("chk_bad_flags", 64'({nD[7:0], nE[7:0]}), 64'({8'd0, 8'd1}));
`endif

    for (int it = 0; it < 25; it++) begin
      int b, n, abortAt;
      b = $urandom_range(0, 31);
      n = ($urandom_range(3) != 0) ? $urandom_range(0, 32 - b) : $urandom_range(0, 32);
      abortAt = ($urandom_range(3) == 0) ? $urandom_range(0, 40) : -1;
      applyStimulus($sformatf("rand%0d", it), b, n, N_ROW'($urandom_range(0, 15)),
                    $urandom_range(30, 100), 0, 0, abortAt, 1'($urandom_range(1)),
                    0, ($urandom_range(3) == 0) ? 1 : 0, nW, nD, nE);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
